mult_div_unit: RTL
==================

# mult_div_unit

Multiply/divide unit for the E stage of the five-stage MIPS pipeline. It owns the HI/LO registers and executes mult/multu/div/divu with fixed multi-cycle latency. It executes mthi/mtlo in one cycle and returns mfhi/mflo read data. It produces the `busy` flag that the stall controller combines with its own E-stage `start` decode to hold MDU-type instructions in D.

## Interface
Parameters:
- MULT_CYCLES, 5: cycles `busy` stays high after a multiply starts.
- DIV_CYCLES, 10: cycles `busy` stays high after a divide starts.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  E-stage instruction is mult/multu/div/divu (or madd/maddu when configured); same signal the stall controller sees.
- mdu_op  input  4  E-stage MDU operation (encodings in Structure).
- A  input  32  forwarded rs value in E.
- B  input  32  forwarded rt value in E.
- busy  output  1  registered; high while a multi-cycle op is in flight.
- HI  output  32  committed HI register.
- LO  output  32  committed LO register.
- mdu_out  output  32  combinational: HI for MFHI, LO for MFLO, else 0.

## Operation
- Reset values: busy=0, HI=0, LO=0, internal counter=0, pending result=0; mdu_out=0.
- State machine has two states:
  - IDLE: counter==0, busy=0.
  - RUN: counter>0, busy=1.
- IDLE, start=1: latch the 64-bit result of the op on A/B into the pending register. Load counter with MULT_CYCLES or DIV_CYCLES. Go to RUN.
- RUN: decrement counter each cycle. On the edge where counter goes 1→0, write pending result to HI/LO, clear busy, return to IDLE.
- Arithmetic:
  - mult: signed 32×32→64, {HI,LO}=product.
  - multu: unsigned 32×32→64, {HI,LO}=product.
  - div: signed; LO=quotient, HI=remainder, truncated toward zero, remainder sign follows dividend.
  - divu: unsigned; LO=quotient, HI=remainder.
- Divide by zero (B==0): the op still runs DIV_CYCLES with busy high. HI and LO stay unchanged at completion.
- mthi: HI←A at the edge. mtlo: LO←A at the edge. Valid only in IDLE; ignored while busy.
- mfhi/mflo: mdu_out reflects committed HI/LO, never the pending result.
- start while busy: ignored. The stall controller guarantees this cannot happen; the bench checks the guarantee with an assertion.
- start with mdu_op not a multiply/divide opcode: treated as no-op, no state change.
- Reset mid-operation: pending result discarded, busy=0, HI=LO=0 on that edge.

## Timing
- Cycle t: op in E with start=1.
- busy high from t+1 through t+N inclusive (N=MULT_CYCLES or DIV_CYCLES). busy=0 at t+N+1.
- HI/LO hold the new values from t+N+1.
- An mfhi issued back-to-back is held in D by the stall controller while start||busy. It reaches E no earlier than t+N+1 and reads the new value with no extra forwarding.
- mthi/mtlo: one-cycle latency; new value visible on HI/LO and mdu_out the next cycle.

## Configuration
- MDU_MADD_EN defined: adds madd (signed) and maddu (unsigned). Each computes {HI,LO}+A×B, 64-bit wrap-around, using MULT_CYCLES latency and the same busy/commit rules. The addend is HI/LO as committed at the start cycle.
- MDU_MADD_EN undefined: madd/maddu opcodes are treated as no-ops; no accumulate adder is synthesized.

## Structure
- Shared macro header holds the MDU op encodings:
  - MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4
  - MDU_MFHI=5, MDU_MFLO=6, MDU_MTHI=7, MDU_MTLO=8
  - MDU_MADD=9, MDU_MADDU=10
- Default latency constants also live there, next to the existing Tnew/Tuse macros.
- The DECODER gains an mdu_op output. The stall controller's MDU_IR classification uses the same encodings.
- No sub-module: counter, pending register and HI/LO fit in one module.

## Test plan
- A=0xFFFFFFFD (-3), B=5, mult: busy high exactly 5 cycles. Afterwards HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- A=0xFFFFFFFF, B=2, multu: HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- A=0xFFFFFFF9 (-7), B=2, div: busy 10 cycles. Then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Repeat with divu A=7, B=0: 10 busy cycles, HI/LO unchanged.
- mthi A=0x12345678, next cycle mfhi: mdu_out=0x12345678. Mflo during an in-flight mult returns the old LO.
- Start mult, assert reset at busy cycle 3: next cycle busy=0, HI=LO=0. A later mult completes normally.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then maddu A=1, B=1: HI=0x00000001, LO=0x00000000 after 5 busy cycles.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared definitions for the E-stage multiply/divide unit.
//   - mdu_op_e     : MDU operation encodings (also used by decoder and stall controller)
//   - mdu_state_e  : MDU sequencer states
//   - Mdu*Default  : default multi-cycle latencies
//   - div_result   : 32/32 divide returning {remainder, quotient}
package mult_div_unit_pkg;

  localparam int unsigned MduMultCyclesDefault = 5;
  localparam int unsigned MduDivCyclesDefault  = 10;

  typedef enum logic [3:0] {
    MduNone  = 4'd0,
    MduMult  = 4'd1,
    MduMultu = 4'd2,
    MduDiv   = 4'd3,
    MduDivu  = 4'd4,
    MduMfhi  = 4'd5,
    MduMflo  = 4'd6,
    MduMthi  = 4'd7,
    MduMtlo  = 4'd8,
    MduMadd  = 4'd9,
    MduMaddu = 4'd10
  } mdu_op_e;

  typedef enum logic {
    StIdle,
    StRun
  } mdu_state_e;

  // Divide on magnitudes so the signed case truncates toward zero with the
  // remainder taking the dividend's sign, and -2^31 / -1 wraps cleanly.
  function automatic logic [63:0] div_result(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        is_signed);
    logic        a_neg;
    logic        b_neg;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] q;
    logic [31:0] r;
    a_neg = is_signed & a[31];
    b_neg = is_signed & b[31];
    ua    = a_neg ? (32'd0 - a) : a;
    ub    = b_neg ? (32'd0 - b) : b;
    // Divide-by-zero results are never committed; keep the divider defined.
    if (ub == 32'd0) ub = 32'd1;
    q = ua / ub;
    r = ua % ub;
    if (a_neg ^ b_neg) q = 32'd0 - q;
    if (a_neg) r = 32'd0 - r;
    return {r, q};
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit owning the HI/LO registers.
// Multiplies and divides run for a fixed MULT_CYCLES / DIV_CYCLES with busy high;
// the result is computed at start, held in a pending register and committed to
// HI/LO on the final busy edge. mthi/mtlo write in one cycle when idle.
// Optional feature macro: MDU_MADD_EN adds madd/maddu ({HI,LO} += A*B).
// Ports:
//   clk      in   pipeline clock
//   reset    in   synchronous active-high reset
//   start    in   E-stage op is a multi-cycle MDU op
//   mdu_op   in   [3:0] MDU operation (mdu_op_e)
//   A, B     in   [31:0] forwarded rs / rt
//   busy     out  registered, high while an op is in flight
//   HI, LO   out  [31:0] committed HI/LO
//   mdu_out  out  [31:0] HI for mfhi, LO for mflo, else 0 (combinational)
// MULT_CYCLES and DIV_CYCLES must both be at least 1.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MduMultCyclesDefault,
  parameter int unsigned DIV_CYCLES  = MduDivCyclesDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] mdu_out
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  mdu_state_e      r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_busy;
  logic [31:0]     r_hi;
  logic [31:0]     r_lo;
  logic [63:0]     r_pending;
  logic            r_commit;

  mdu_op_e         w_op;
  logic            w_is_mult;
  logic            w_is_div;
  logic            w_is_madd;
  logic            w_signed;
  logic            w_valid_start;
  logic            w_commit;
  logic [63:0]     w_prod;
  logic [63:0]     w_result;
  logic [CntW-1:0] w_cycles;

  always_comb begin
    w_op      = mdu_op_e'(mdu_op);
    w_is_mult = (w_op == MduMult) || (w_op == MduMultu);
    w_is_div  = (w_op == MduDiv) || (w_op == MduDivu);
`ifdef MDU_MADD_EN
    w_is_madd = (w_op == MduMadd) || (w_op == MduMaddu);
`else
    w_is_madd = 1'b0;
`endif
    w_signed  = (w_op == MduMult) || (w_op == MduDiv) || (w_op == MduMadd);
    // Low 64 bits of the product of the sign/zero-extended operands.
    w_prod    = w_signed ? ({{32{A[31]}}, A} * {{32{B[31]}}, B})
                         : ({32'd0, A} * {32'd0, B});

    w_result = w_prod;
    w_commit = 1'b1;
    w_cycles = CntW'(MULT_CYCLES);
`ifdef MDU_MADD_EN
    // Addend is HI/LO as committed in the start cycle.
    if (w_is_madd) w_result = {r_hi, r_lo} + w_prod;
`endif
    if (w_is_div) begin
      w_result = div_result(A, B, w_signed);
      w_cycles = CntW'(DIV_CYCLES);
      w_commit = (B != 32'd0);
    end

    w_valid_start = start && (w_is_mult || w_is_div || w_is_madd);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pending <= '0;
      r_commit  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_valid_start) begin
            r_pending <= w_result;
            r_commit  <= w_commit;
            r_cnt     <= w_cycles;
            r_busy    <= 1'b1;
            r_state   <= StRun;
          end else if (!start) begin
            // A start with a non-multi-cycle opcode is a no-op, so moves need !start.
            if (w_op == MduMthi) r_hi <= A;
            if (w_op == MduMtlo) r_lo <= A;
          end
        end
        StRun: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CntW'(1)) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
            if (r_commit) begin
              r_hi <= r_pending[63:32];
              r_lo <= r_pending[31:0];
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

  always_comb begin
    mdu_out = '0;
    if (w_op == MduMfhi) mdu_out = r_hi;
    if (w_op == MduMflo) mdu_out = r_lo;
  end

endmodule
